// File: rtl/npu_pkg.sv
// npu_pkg: op codes, FSM states, frame field positions and error codes shared by the tile scheduler
package npu_pkg;
  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_MAC    = 3'd1,
    OP_LOAD_W = 3'd2,
    OP_LOAD_A = 3'd3,
    OP_READ   = 3'd4
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  localparam int OP_MSB   = 23;
  localparam int OP_LSB   = 21;
  localparam int TI_MSB   = 20;
  localparam int TI_LSB   = 18;
  localparam int TJ_MSB   = 17;
  localparam int TJ_LSB   = 15;
  localparam int RSVD_MSB = 14;
  localparam int RSVD_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  localparam int QW       = 17;
  localparam logic [7:0] RSP_ILLEGAL = 8'hFF;
  localparam logic [7:0] RSP_TIMEOUT = 8'hEE;
  function automatic logic needs_dp(input logic [2:0] op);
    return op inside {OP_MAC, OP_LOAD_W, OP_LOAD_A, OP_READ};
  endfunction
endpackage

// File: rtl/npu_cmd_fifo.sv
// npu_cmd_fifo: power-of-two circular command queue; pushes while full are dropped
module npu_cmd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = (do_push && !do_pop) ? cnt_q + 1'b1 : (do_pop && !do_push) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/npu_tile_scheduler.sv
// npu_tile_scheduler: queues SPI command frames and runs them one at a time on the tile datapath
module npu_tile_scheduler
  import npu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [23:0]                 cmd_frame,
  output logic                        dp_start,
  output logic [2:0]                  dp_op,
  output logic [2:0]                  dp_tile_i,
  output logic [2:0]                  dp_tile_j,
  output logic [7:0]                  dp_data,
  input  logic                        dp_busy,
  input  logic                        dp_done,
  input  logic [7:0]                  dp_result,
  output logic                        rsp_valid,
  output logic [7:0]                  rsp_data,
  output logic                        rsp_err,
  input  logic                        rsp_ready,
  output logic                        done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  state_e state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] opnd_q, opnd_d, head;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic rsp_err_q, rsp_err_d;
  logic [2:0] head_op;
  logic full, empty, pop;
  logic unused_rsvd;
  assign unused_rsvd = ^cmd_frame[RSVD_MSB:RSVD_LSB];
  npu_cmd_fifo #(.WIDTH(QW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata ({cmd_frame[OP_MSB:TJ_LSB], cmd_frame[DATA_MSB:DATA_LSB]}),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );
  assign head_op   = head[QW-1 -: 3];
  assign cmd_ready = !full;
  assign dp_start  = state_q == S_ISSUE;
  assign rsp_valid = state_q == S_RESP;
  assign done      = rsp_valid && rsp_ready;
  assign busy      = state_q != S_IDLE || !empty;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign {dp_op, dp_tile_i, dp_tile_j, dp_data} = opnd_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE:
        if (!empty) begin
          if (needs_dp(head_op)) begin
            if (!dp_busy) begin
              pop     = 1'b1;
              opnd_d  = head;
              state_d = S_ISSUE;
            end
          end else begin
            pop        = 1'b1;
            rsp_data_d = (head_op == OP_NOP) ? 8'h00 : RSP_ILLEGAL;
            rsp_err_d  = head_op != OP_NOP;
            state_d    = S_RESP;
          end
        end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT:
        if (dp_done) begin
          rsp_data_d = dp_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          rsp_data_d = RSP_TIMEOUT;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      S_RESP:
        if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opnd_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
endmodule

// File: tb/tb_npu_tile_scheduler.sv
// tb_npu_tile_scheduler: directed scenarios plus a randomized in-order scoreboard run for the tile scheduler
module tb_npu_tile_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, dp_busy = 1'b0, dp_done = 1'b0, rsp_ready = 1'b0;
  logic [23:0] cmd_frame = '0;
  logic [7:0] dp_result = '0;
  logic cmd_ready, dp_start, rsp_valid, rsp_err, done, busy;
  logic [2:0] dp_op, dp_tile_i, dp_tile_j, fifo_count;
  logic [7:0] dp_data, rsp_data;
  int checks = 0, errors = 0;
  int cyc = 0, n_done = 0, n_start = 0, last_done_cyc = 0, last_start_cyc = 0;

  always #5 clk = ~clk;

  npu_tile_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_frame(cmd_frame),
    .dp_start(dp_start), .dp_op(dp_op), .dp_tile_i(dp_tile_i), .dp_tile_j(dp_tile_j), .dp_data(dp_data),
    .dp_busy(dp_busy), .dp_done(dp_done), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .done(done), .busy(busy), .fifo_count(fifo_count)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) begin n_done <= n_done + 1; last_done_cyc <= cyc + 1; end
    if (dp_start) begin n_start <= n_start + 1; last_start_cyc <= cyc + 1; end
  end

  function automatic logic [23:0] frm(input logic [2:0] op, input logic [2:0] ti, input logic [2:0] tj, input logic [7:0] d);
    return {op, ti, tj, 7'h2B, d};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [23:0] f);
    cmd_valid = 1'b1; cmd_frame = f;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic serve(input bit use_dp, input int delay, input logic [7:0] res, input int rdy_wait,
                       output logic [16:0] opnd, output logic [7:0] rdata, output logic rerr, output bit ok);
    int t;
    ok = 1'b1; opnd = '0;
    if (use_dp) begin
      t = 0;
      while (dp_start !== 1'b1 && t < 100) begin step(); t++; end
      if (dp_start !== 1'b1) ok = 1'b0;
      opnd = {dp_op, dp_tile_i, dp_tile_j, dp_data};
      repeat (delay) step();
      dp_done = 1'b1; dp_result = res;
      step();
      dp_done = 1'b0; dp_result = '0;
    end
    t = 0;
    while (rsp_valid !== 1'b1 && t < 100) begin step(); t++; end
    if (rsp_valid !== 1'b1) ok = 1'b0;
    repeat (rdy_wait) step();
    rdata = rsp_data; rerr = rsp_err;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if ({dp_start, rsp_valid, rsp_err, done, busy} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b exp 00000", {dp_start, rsp_valid, rsp_err, done, busy}); end
    checks++; if ({dp_op, dp_tile_i, dp_tile_j, dp_data} !== 17'h0) begin errors++; $display("FAIL reset_operands: got %h exp 0", {dp_op, dp_tile_i, dp_tile_j, dp_data}); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h exp 00", rsp_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d exp 0", fifo_count); end
    rst_n = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_single_mac();
    int s0, d0;
    s0 = n_start; d0 = n_done;
    push(frm(3'd1, 3'd3, 3'd5, 8'h2A));
    checks++; if (fifo_count !== 3'd1 || dp_start !== 1'b0) begin errors++; $display("FAIL mac_queued: count %0d start %b exp 1 0", fifo_count, dp_start); end
    step();
    checks++; if (dp_start !== 1'b1) begin errors++; $display("FAIL mac_dp_start: got %b exp 1", dp_start); end
    checks++; if ({dp_op, dp_tile_i, dp_tile_j, dp_data} !== {3'd1, 3'd3, 3'd5, 8'h2A}) begin errors++; $display("FAIL mac_operands: got %h exp %h", {dp_op, dp_tile_i, dp_tile_j, dp_data}, {3'd1, 3'd3, 3'd5, 8'h2A}); end
    step();
    checks++; if (dp_start !== 1'b0) begin errors++; $display("FAIL mac_start_pulse: got %b exp 0", dp_start); end
    step();
    dp_done = 1'b1; dp_result = 8'h7C;
    checks++; if ({dp_tile_i, dp_tile_j, dp_data} !== {3'd3, 3'd5, 8'h2A}) begin errors++; $display("FAIL mac_operands_held: got %h exp %h", {dp_tile_i, dp_tile_j, dp_data}, {3'd3, 3'd5, 8'h2A}); end
    step();
    dp_done = 1'b0; dp_result = '0;
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h7C}) begin errors++; $display("FAIL mac_rsp: got v%b e%b %h exp v1 e0 7c", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 1'b1; #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mac_done: got %b exp 1", done); end
    step();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL mac_idle: got %b exp 000", {rsp_valid, busy, done}); end
    checks++; if (n_start - s0 !== 1 || n_done - d0 !== 1) begin errors++; $display("FAIL mac_pulse_counts: starts %0d dones %0d exp 1 1", n_start - s0, n_done - d0); end
  endtask

  task automatic test_min_latency();
    push(frm(3'd4, 3'd1, 3'd2, 8'h11));
    step();
    checks++; if (dp_start !== 1'b1) begin errors++; $display("FAIL lat_dp_start: got %b exp 1", dp_start); end
    step();
    dp_done = 1'b1; dp_result = 8'h99;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_early_rsp: got %b exp 0", rsp_valid); end
    step();
    dp_done = 1'b0; dp_result = '0;
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h99}) begin errors++; $display("FAIL lat_dp_rsp: got v%b %h exp v1 99", rsp_valid, rsp_data); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    push(frm(3'd0, 3'd7, 3'd7, 8'h55));
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_nop_early: got %b exp 0", rsp_valid); end
    step();
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h00}) begin errors++; $display("FAIL lat_nop_rsp: got v%b e%b %h exp v1 e0 00", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_illegal_nop();
    int s0, d0;
    s0 = n_start; d0 = n_done;
    cmd_valid = 1'b1; cmd_frame = frm(3'd6, 3'd2, 3'd2, 8'h12);
    step();
    cmd_frame = frm(3'd0, 3'd1, 3'd1, 8'h77);
    step();
    cmd_valid = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 8'hFF}) begin errors++; $display("FAIL ill_rsp: got v%b e%b %h exp v1 e1 ff", rsp_valid, rsp_err, rsp_data); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL ill_count: got %0d exp 1", fifo_count); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_gap: got %b exp 0", rsp_valid); end
    step();
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h00}) begin errors++; $display("FAIL nop_rsp: got v%b e%b %h exp v1 e0 00", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if (n_start - s0 !== 0 || n_done - d0 !== 2) begin errors++; $display("FAIL ill_nop_counts: starts %0d dones %0d exp 0 2", n_start - s0, n_done - d0); end
  endtask

  task automatic test_fill_overflow();
    logic [16:0] opnd; logic [7:0] rd; logic re; bit ok; int d0;
    d0 = n_done; rsp_ready = 1'b0; dp_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_frame = frm(3'(i % 4 + 1), 3'(i), 3'(7 - i), 8'hA0 + 8'(i));
      step();
      if (i == 3) begin
        checks++; if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin errors++; $display("FAIL fill_full: ready %b count %0d exp 0 4", cmd_ready, fifo_count); end
      end
    end
    cmd_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4 || busy !== 1'b1) begin errors++; $display("FAIL fill_drop: count %0d busy %b exp 4 1", fifo_count, busy); end
    dp_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, 2, 8'h40 + 8'(i), 1, opnd, rd, re, ok);
      checks++; if (!ok || opnd !== {3'(i % 4 + 1), 3'(i), 3'(7 - i), 8'hA0 + 8'(i)} || rd !== 8'h40 + 8'(i) || re !== 1'b0) begin errors++; $display("FAIL fill_rsp%0d: ok %b opnd %h rsp %h err %b exp opnd %h rsp %h err 0", i, ok, opnd, rd, re, {3'(i % 4 + 1), 3'(i), 3'(7 - i), 8'hA0 + 8'(i)}, 8'h40 + 8'(i)); end
    end
    repeat (5) step();
    checks++; if (fifo_count !== 3'd0 || busy !== 1'b0 || n_done - d0 !== 4) begin errors++; $display("FAIL fill_drain: count %0d busy %b dones %0d exp 0 0 4", fifo_count, busy, n_done - d0); end
  endtask

  task automatic test_timeout();
    int t;
    rsp_ready = 1'b0;
    push(frm(3'd1, 3'd0, 3'd0, 8'h01));
    t = 0; while (dp_start !== 1'b1 && t < 10) begin step(); t++; end
    checks++; if (dp_start !== 1'b1) begin errors++; $display("FAIL to_start: got %b exp 1", dp_start); end
    repeat (16) step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early: got %b exp 0", rsp_valid); end
    step();
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 8'hEE}) begin errors++; $display("FAIL to_rsp: got v%b e%b %h exp v1 e1 ee", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    push(frm(3'd2, 3'd1, 3'd1, 8'h02));
    t = 0; while (dp_start !== 1'b1 && t < 10) begin step(); t++; end
    repeat (16) step();
    dp_done = 1'b1; dp_result = 8'h5A;
    step();
    dp_done = 1'b0; dp_result = '0;
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h5A}) begin errors++; $display("FAIL to_done_wins: got v%b e%b %h exp v1 e0 5a", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    dp_done = 1'b1; dp_result = 8'h33;
    step();
    dp_done = 1'b0; dp_result = '0;
    step();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL stray_done: got %b exp 00", {rsp_valid, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] o1, o2; logic [7:0] r1, r2; logic e1, e2; bit ok1, ok2; int hd;
    rsp_ready = 1'b0; dp_busy = 1'b1;
    push(frm(3'd3, 3'd4, 3'd6, 8'hB1));
    push(frm(3'd1, 3'd5, 3'd2, 8'hB2));
    dp_busy = 1'b0;
    serve(1'b1, 1, 8'hC1, 0, o1, r1, e1, ok1);
    hd = last_done_cyc;
    serve(1'b1, 3, 8'hC2, 2, o2, r2, e2, ok2);
    checks++; if (!ok1 || o1 !== {3'd3, 3'd4, 3'd6, 8'hB1} || r1 !== 8'hC1 || e1 !== 1'b0) begin errors++; $display("FAIL b2b_first: ok %b opnd %h rsp %h err %b exp %h c1 0", ok1, o1, r1, e1, {3'd3, 3'd4, 3'd6, 8'hB1}); end
    checks++; if (!ok2 || o2 !== {3'd1, 3'd5, 3'd2, 8'hB2} || r2 !== 8'hC2 || e2 !== 1'b0) begin errors++; $display("FAIL b2b_second: ok %b opnd %h rsp %h err %b exp %h c2 0", ok2, o2, r2, e2, {3'd1, 3'd5, 3'd2, 8'hB2}); end
    checks++; if (last_start_cyc - hd !== 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles exp 2", last_start_cyc - hd); end
  endtask

  task automatic test_reset_mid_wait();
    int t, s0, d0;
    rsp_ready = 1'b0; dp_busy = 1'b1;
    push(frm(3'd1, 3'd1, 3'd1, 8'hD1));
    push(frm(3'd2, 3'd2, 3'd2, 8'hD2));
    push(frm(3'd3, 3'd3, 3'd3, 8'hD3));
    dp_busy = 1'b0;
    t = 0; while (dp_start !== 1'b1 && t < 10) begin step(); t++; end
    step();
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rst_wait_count: got %0d exp 2", fifo_count); end
    s0 = n_start; d0 = n_done;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_async_count: got %0d exp 0", fifo_count); end
    checks++; if ({dp_start, rsp_valid, rsp_err, done, busy, cmd_ready} !== 6'b000001) begin errors++; $display("FAIL rst_async_flags: got %b exp 000001", {dp_start, rsp_valid, rsp_err, done, busy, cmd_ready}); end
    checks++; if ({dp_op, dp_tile_i, dp_tile_j, dp_data, rsp_data} !== 25'h0) begin errors++; $display("FAIL rst_async_data: got %h exp 0", {dp_op, dp_tile_i, dp_tile_j, dp_data, rsp_data}); end
    step(); step();
    rst_n = 1'b1; rsp_ready = 1'b1;
    repeat (5) step();
    dp_done = 1'b1; dp_result = 8'h44;
    step();
    dp_done = 1'b0; dp_result = '0;
    repeat (20) step();
    rsp_ready = 1'b0;
    checks++; if (n_done !== d0 || n_start !== s0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_ghost: dones %0d starts %0d busy %b exp 0 0 0", n_done - d0, n_start - s0, busy); end
  endtask

  task automatic test_random();
    logic [23:0] exp_q[$];
    logic [23:0] e;
    logic [16:0] opnd;
    logic [7:0] rd, res, exp_d;
    logic re, exp_e;
    bit ok, dp;
    int k, cmds, accepted, d0;
    cmds = 0; accepted = 0; d0 = n_done;
    while (cmds < 1000) begin
      k = $urandom_range(1, 4);
      rsp_ready = 1'b0; dp_busy = 1'b1;
      for (int i = 0; i < k; i++) begin
        e = 24'($urandom);
        exp_q.push_back(e);
        push(e);
      end
      accepted += k;
      dp_busy = 1'b0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        dp = e[23:21] >= 3'd1 && e[23:21] <= 3'd4;
        res = 8'($urandom);
        serve(dp, $urandom_range(1, 10), res, $urandom_range(0, 3), opnd, rd, re, ok);
        exp_d = dp ? res : (e[23:21] == 3'd0 ? 8'h00 : 8'hFF);
        exp_e = !dp && e[23:21] != 3'd0;
        checks++;
        if (!ok || rd !== exp_d || re !== exp_e || (dp && opnd !== {e[23:15], e[7:0]})) begin
          errors++;
          $display("FAIL rand_cmd%0d: ok %b rsp %h err %b opnd %h exp rsp %h err %b opnd %h", cmds, ok, rd, re, opnd, exp_d, exp_e, {e[23:15], e[7:0]});
        end
        cmds++;
      end
    end
    repeat (3) step();
    checks++; if (n_done - d0 !== accepted) begin errors++; $display("FAIL rand_done_count: got %0d exp %0d", n_done - d0, accepted); end
  endtask

  initial begin
    test_reset();
    test_single_mac();
    test_min_latency();
    test_illegal_nop();
    test_fill_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/npu_tile_scheduler.md
NPU_TILE_SCHEDULER -- requirements
Module: npu_tile_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, maximum clk cycles spent in WAIT before abort.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command frame offered by the SPI front end.
REQ-006 SHALL have port cmd_ready  output  1  queue can accept; equals (count < FIFO_DEPTH).
REQ-007 SHALL have port cmd_frame  input  24  fields: [23:21] op_code, [20:18] tile_i, [17:15] tile_j, [14:8] reserved (ignored), [7:0] data.
REQ-008 SHALL have port dp_start  output  1  one-cycle pulse launching a tile operation.
REQ-009 SHALL have ports dp_op (3), dp_tile_i (3), dp_tile_j (3), dp_data (8)  output  operands, held stable from dp_start until dp_done.
REQ-010 SHALL have ports dp_busy  input  1, dp_done  input  1 (one-cycle pulse), dp_result  input  8.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_data  output  8, rsp_err  output  1, rsp_ready  input  1.
REQ-012 SHALL have port done  output  1  one-cycle pulse per retired command.
REQ-013 SHALL have ports busy  output  1 (state != IDLE or queue non-empty), fifo_count  output  $clog2(FIFO_DEPTH)+1.

Function
REQ-014 SHALL decode op_code: 0 NOP, 1 MAC, 2 LOAD_W, 3 LOAD_A, 4 READ; 5-7 ILLEGAL.
REQ-015 SHALL push cmd_frame on cmd_valid && cmd_ready; frames offered while full are dropped (not stored, no error).
REQ-016 SHALL support simultaneous push and pop when full or empty-with-pop-not-possible rules hold: push+pop in the same cycle leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if queue non-empty, pop head; MAC/LOAD_W/LOAD_A/READ with dp_busy==0 -> ISSUE; NOP -> RESP with rsp_data=0, rsp_err=0; ILLEGAL -> RESP with rsp_data=8'hFF, rsp_err=1; if dp_busy==1 and head needs datapath, do not pop, stay IDLE.
REQ-019 ISSUE: dp_start=1 for exactly one cycle, operands registered from popped frame -> WAIT.
REQ-020 WAIT: on dp_done capture dp_result into rsp_data, rsp_err=0 -> RESP; dp_done in cycle following dp_start is legal.
REQ-021 WAIT: cycle counter increments each cycle; reaching TIMEOUT_CYC without dp_done -> RESP with rsp_data=8'hEE, rsp_err=1; if dp_done coincides with the timeout cycle, dp_done wins.
REQ-022 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready; on rsp_valid && rsp_ready pulse done for one cycle, go IDLE.
REQ-023 dp_done outside WAIT SHALL be ignored.
REQ-024 Minimum latency, datapath op: push cycle N, pop N+1, dp_start N+2, dp_done at N+3 -> rsp_valid N+4; NOP: rsp_valid N+2.
REQ-025 Back-to-back: after RESP handshake the next queued command SHALL pop in the following cycle (one-command-in-flight only).

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, queue empty (fifo_count=0), WAIT counter 0, dp_start=0, dp_op/dp_tile_i/dp_tile_j/dp_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, done=0, busy=0; cmd_ready=1 after release.
REQ-027 Reset asserted mid-operation SHALL discard queued and in-flight commands; no done pulse or response for them after release.

Structure
REQ-028 Package npu_pkg SHALL hold the op_code enum, FSM state enum, cmd_frame field bit-position constants and the 8'hFF/8'hEE error codes.
REQ-029 Queue SHALL be a sub-module npu_cmd_fifo (parameterised width/depth, count output); FSM and timeout counter in npu_tile_scheduler.

Verification
REQ-030 Single MAC: push op=1,tile(3,5),data=8'h2A; datapath returns dp_done+8'h7C two cycles after dp_start -> dp_start once with dp_tile_i=3, dp_tile_j=5, dp_data=8'h2A; rsp_data=8'h7C, rsp_err=0, one done pulse.
REQ-031 Fill/overflow: rsp_ready=0, dp_busy=1, push 5 frames with FIFO_DEPTH=4 -> cmd_ready=0 after 4th, fifo_count=4, 5th dropped; release -> exactly 4 responses in push order.
REQ-032 Illegal and NOP: push op=6 then op=0 -> rsp (8'hFF, err=1) then (8'h00, err=0), no dp_start, two done pulses.
REQ-033 Timeout: TIMEOUT_CYC=16, MAC, never assert dp_done -> rsp_data=8'hEE, rsp_err=1 exactly 16 cycles after entering WAIT; variant with dp_done on cycle 16 -> normal result.
REQ-034 Reset mid-WAIT with 2 queued: assert rst_n low -> all outputs at reset values immediately, fifo_count=0, no done after release.
REQ-035 Random 1000 commands with random dp_done delay and rsp_ready back-pressure -> done count equals accepted count, responses in order, scoreboard match.
